// File: rtl/wake_req_ctrl_pkg.sv
// Shared types and default constants for the wake request controller.
package wake_req_ctrl_pkg;

  typedef enum logic [2:0] {
    SLEEP     = 3'd0,
    WAKE_REQ  = 3'd1,
    ISSUE     = 3'd2,
    BUSY_WAIT = 3'd3,
    IDLE      = 3'd4
  } wake_state_e;

  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;
  localparam int unsigned DEF_BUSY_GUARD   = 40;
  localparam int unsigned DEF_IDLE_CYCLES  = 16;
  localparam int unsigned DEF_WAKE_TIMEOUT = 64;

  localparam int unsigned INSTR_CNT_W = 16;
  localparam int unsigned WAKE_CNT_W  = 16;
  localparam int unsigned DROP_CNT_W  = 8;

endpackage

// File: rtl/wake_evt_fifo.sv
// Small synchronous event FIFO with occupancy count; synchronous active-low reset.
module wake_evt_fifo
  import wake_req_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == LVL_W'(0));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/wake_req_ctrl.sv
// Initiator side of the core sleep/wake handshake: buffers events, wakes the core, issues pulses.
// Optional statistics outputs are built when WAKE_REQ_CTRL_STATS_EN is defined.
module wake_req_ctrl
  import wake_req_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned BUSY_GUARD   = DEF_BUSY_GUARD,
  parameter int unsigned IDLE_CYCLES  = DEF_IDLE_CYCLES,
  parameter int unsigned WAKE_TIMEOUT = DEF_WAKE_TIMEOUT
) (
  input  logic                          clk_ungated_i,
  input  logic                          resetn,
  input  logic                          evt_valid_i,
  input  logic [DATA_W-1:0]             evt_data_i,
  output logic                          evt_ready_o,
  input  logic                          core_sleep_i,
  input  logic                          core_busy_i,
  output logic                          wake_from_sleep_o,
  output logic                          new_ascii_instr_o,
  output logic [DATA_W-1:0]             instr_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          wake_err_o
`ifdef WAKE_REQ_CTRL_STATS_EN
  ,
  output logic [INSTR_CNT_W-1:0]        instr_count_o,
  output logic [WAKE_CNT_W-1:0]         wake_count_o,
  output logic [DROP_CNT_W-1:0]         drop_count_o
`endif
);

  localparam int unsigned GRD_W = $clog2(BUSY_GUARD + 1);
  localparam int unsigned IDL_W = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(WAKE_TIMEOUT + 1);
  localparam logic [GRD_W-1:0] GRD_MAX  = GRD_W'(BUSY_GUARD);
  localparam logic [IDL_W-1:0] IDL_LAST = IDL_W'(IDLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAKE_TIMEOUT - 1);

  wake_state_e       state;
  wake_state_e       state_nxt;
  logic [GRD_W-1:0]  guard_cnt;
  logic [GRD_W-1:0]  guard_nxt;
  logic [GRD_W-1:0]  guard_inc;
  logic [IDL_W-1:0]  idle_cnt;
  logic [IDL_W-1:0]  idle_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [TMO_W-1:0]  tmo_nxt;
  logic              err_set;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              has_evt;
  logic [DATA_W-1:0] head;

  assign evt_ready_o = ~full;
  assign push        = evt_valid_i & ~full;
  assign has_evt     = ~empty;

  wake_evt_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk_ungated_i),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (evt_data_i),
    .dout   (head),
    .level  (fifo_level_o),
    .full   (full),
    .empty  (empty)
  );

  // Next-state, counter updates and FIFO pop; an unexpected re-gate always returns to WAKE_REQ.
  always_comb begin
    state_nxt = state;
    guard_nxt = guard_cnt;
    idle_nxt  = idle_cnt;
    tmo_nxt   = '0;
    err_set   = 1'b0;
    pop       = 1'b0;
    guard_inc = (guard_cnt == GRD_MAX) ? guard_cnt : guard_cnt + GRD_W'(1);
    case (state)
      SLEEP: begin
        if (has_evt) state_nxt = WAKE_REQ;
        else         state_nxt = SLEEP;
      end
      WAKE_REQ: begin
        tmo_nxt = (tmo_cnt == TMO_LAST) ? tmo_cnt : tmo_cnt + TMO_W'(1);
        if (!core_sleep_i) begin
          if (has_evt) begin
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
            idle_nxt  = '0;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          err_set = 1'b1;
        end else begin
          state_nxt = WAKE_REQ;
        end
      end
      ISSUE: begin
        if (core_sleep_i) begin
          state_nxt = WAKE_REQ;
        end else begin
          pop       = 1'b1;
          guard_nxt = '0;
          state_nxt = BUSY_WAIT;
        end
      end
      BUSY_WAIT: begin
        if (core_sleep_i) begin
          state_nxt = WAKE_REQ;
        end else begin
          guard_nxt = guard_inc;
          if ((guard_inc == GRD_MAX) && !core_busy_i) begin
            if (has_evt) begin
              state_nxt = ISSUE;
            end else begin
              state_nxt = IDLE;
              idle_nxt  = '0;
            end
          end else begin
            state_nxt = BUSY_WAIT;
          end
        end
      end
      IDLE: begin
        if (core_sleep_i)                state_nxt = WAKE_REQ;
        else if (has_evt)                state_nxt = ISSUE;
        else if (core_busy_i)            idle_nxt  = '0;
        else if (idle_cnt == IDL_LAST)   state_nxt = SLEEP;
        else                             idle_nxt  = idle_cnt + IDL_W'(1);
      end
      default: state_nxt = SLEEP;
    endcase
  end

  // State, counters and registered handshake outputs.
  always_ff @(posedge clk_ungated_i) begin
    if (!resetn) begin
      state             <= SLEEP;
      guard_cnt         <= '0;
      idle_cnt          <= '0;
      tmo_cnt           <= '0;
      wake_from_sleep_o <= 1'b0;
      new_ascii_instr_o <= 1'b0;
      instr_data_o      <= '0;
      wake_err_o        <= 1'b0;
    end else begin
      state             <= state_nxt;
      guard_cnt         <= guard_nxt;
      idle_cnt          <= idle_nxt;
      tmo_cnt           <= tmo_nxt;
      wake_from_sleep_o <= (state != SLEEP);
      new_ascii_instr_o <= pop;
      instr_data_o      <= pop ? head : instr_data_o;
      wake_err_o        <= wake_err_o | err_set;
    end
  end

`ifdef WAKE_REQ_CTRL_STATS_EN
  // Issue, wake-up and dropped-event statistics; the drop count saturates.
  always_ff @(posedge clk_ungated_i) begin
    if (!resetn) begin
      instr_count_o <= '0;
      wake_count_o  <= '0;
      drop_count_o  <= '0;
    end else begin
      instr_count_o <= instr_count_o + INSTR_CNT_W'(pop);
      wake_count_o  <= wake_count_o + WAKE_CNT_W'((state == SLEEP) && (state_nxt == WAKE_REQ));
      if (evt_valid_i && full && (drop_count_o != {DROP_CNT_W{1'b1}})) begin
        drop_count_o <= drop_count_o + DROP_CNT_W'(1);
      end else begin
        drop_count_o <= drop_count_o;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wake_req_ctrl.sv
// Directed and randomized bench for wake_req_ctrl against a queue/timestamp reference model.
module tb_wake_req_ctrl;

  localparam int FIFO_DEPTH   = 4;
  localparam int BUSY_GUARD   = 40;
  localparam int IDLE_CYCLES  = 16;
  localparam int WAKE_TIMEOUT = 64;
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             evt_valid = 1'b0;
  logic [7:0]       evt_data = 8'h00;
  logic             core_sleep = 1'b1;
  logic             core_busy = 1'b0;
  logic             evt_ready;
  logic             wake;
  logic             pulse;
  logic [7:0]       instr_data;
  logic [LVL_W-1:0] fifo_level;
  logic             wake_err;
`ifdef WAKE_REQ_CTRL_STATS_EN
  logic [15:0]      instr_count;
  logic [15:0]      wake_count;
  logic [7:0]       drop_count;
`endif

  wake_req_ctrl dut (
    .clk_ungated_i     (clk),
    .resetn            (resetn),
    .evt_valid_i       (evt_valid),
    .evt_data_i        (evt_data),
    .evt_ready_o       (evt_ready),
    .core_sleep_i      (core_sleep),
    .core_busy_i       (core_busy),
    .wake_from_sleep_o (wake),
    .new_ascii_instr_o (pulse),
    .instr_data_o      (instr_data),
    .fifo_level_o      (fifo_level),
    .wake_err_o        (wake_err)
`ifdef WAKE_REQ_CTRL_STATS_EN
    ,
    .instr_count_o     (instr_count),
    .wake_count_o      (wake_count),
    .drop_count_o      (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: event queue plus timestamps of the handshake milestones.
  logic [7:0] q[$];
  bit   m_on, m_waiting, m_issue, m_guard;
  int   m_t_req, m_t_issue, m_t_idle;
  int   cyc = 0;
  bit   e_wake, e_pulse, e_err, e_ready;
  logic [7:0] e_data;
  int   e_level;
  int   m_instr, m_wakes, m_drop;

  int   pulse_cnt = 0;
  int   pulse_cyc[$];
  logic [7:0] pulse_dat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int lvl;
    bit do_pop;
    if (resetn !== 1'b1) begin
      q.delete();
      m_on = 0; m_waiting = 0; m_issue = 0; m_guard = 0;
      m_t_req = 0; m_t_issue = 0; m_t_idle = 0;
      e_wake = 0; e_pulse = 0; e_err = 0; e_data = 8'h00;
      m_instr = 0; m_wakes = 0; m_drop = 0;
    end else begin
      lvl    = q.size();
      do_pop = m_issue && !core_sleep;
      e_wake  = m_on;
      e_pulse = do_pop;
      if (do_pop) e_data = q[0];
      if (m_waiting && core_sleep && (cyc - m_t_req >= WAKE_TIMEOUT - 1)) e_err = 1;
      if (evt_valid && lvl == FIFO_DEPTH && m_drop < 255) m_drop++;
      if (do_pop) m_instr = (m_instr + 1) % 65536;
      if (!m_on) begin
        if (lvl > 0) begin
          m_on = 1; m_waiting = 1; m_t_req = cyc + 1;
          m_wakes = (m_wakes + 1) % 65536;
        end
      end else if (m_waiting) begin
        if (!core_sleep) begin
          m_waiting = 0;
          if (lvl > 0) m_issue = 1;
          else m_t_idle = cyc + 1;
        end
      end else if (core_sleep) begin
        m_waiting = 1; m_issue = 0; m_guard = 0; m_t_req = cyc + 1;
      end else if (m_issue) begin
        m_issue = 0; m_guard = 1; m_t_issue = cyc;
      end else if (m_guard) begin
        if (cyc - m_t_issue >= BUSY_GUARD && !core_busy) begin
          m_guard = 0;
          if (lvl > 0) m_issue = 1;
          else m_t_idle = cyc + 1;
        end
      end else begin
        if (lvl > 0) m_issue = 1;
        else if (core_busy) m_t_idle = cyc + 1;
        else if (cyc - m_t_idle >= IDLE_CYCLES - 1) m_on = 0;
      end
      if (do_pop) void'(q.pop_front());
      if (evt_valid && lvl != FIFO_DEPTH) q.push_back(evt_data);
    end
    e_level = q.size();
    e_ready = (q.size() != FIFO_DEPTH);
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("wake", wake, e_wake);
    chk("pulse", pulse, e_pulse);
    chk("instr_data", instr_data, e_data);
    chk("evt_ready", evt_ready, e_ready);
    chk("fifo_level", fifo_level, e_level);
    chk("wake_err", wake_err, e_err);
`ifdef WAKE_REQ_CTRL_STATS_EN
    chk("instr_count", instr_count, m_instr);
    chk("wake_count", wake_count, m_wakes);
    chk("drop_count", drop_count, m_drop);
`endif
    if (pulse === 1'b1) begin
      pulse_cnt++;
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(instr_data);
    end
  endtask

  initial begin
    int p0, n, k0;

    // Reset, then a long quiet stretch with no events.
    resetn = 1'b0;
    repeat (3) tick();
    chk("rst_ready", evt_ready, 1);
    chk("rst_wake", wake, 0);
    resetn = 1'b1;
    repeat (200) tick();
    chk("idle_wake", wake, 0);

    // Single event; the core wakes two cycles after the request is seen.
    evt_valid = 1'b1; evt_data = 8'h41;
    tick();
    evt_valid = 1'b0;
    for (int i = 0; i < 10 && wake !== 1'b1; i++) tick();
    chk("wake_rise", wake, 1);
    p0 = pulse_cnt;
    tick(); tick();
    core_sleep = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && wake === 1'b1; i++) begin tick(); n++; end
    chk("wake_fall", wake, 0);
    chk("single_pulses", pulse_cnt - p0, 1);
    chk("single_data", pulse_dat[pulse_dat.size()-1], 8'h41);
    chk("wake_hold", (n >= BUSY_GUARD + IDLE_CYCLES) ? 1 : 0, 1);
    core_sleep = 1'b1;
    tick();

    // Burst of five with the core asleep: the fifth is refused.
    for (int k = 0; k < 5; k++) begin
      evt_valid = 1'b1; evt_data = 8'h41 + 8'(k);
      if (k == 4) chk("full_ready", evt_ready, 0);
      tick();
    end
    evt_valid = 1'b0;
    chk("burst_level", fifo_level, 4);
`ifdef WAKE_REQ_CTRL_STATS_EN
    chk("burst_drop", drop_count, 1);
`endif
    core_sleep = 1'b0;
    p0 = pulse_cnt; k0 = pulse_cyc.size();
    for (int i = 0; i < 400 && (pulse_cnt - p0 < 4 || wake === 1'b1); i++) tick();
    chk("burst_pulses", pulse_cnt - p0, 4);
    for (int k = 0; k < 4 && k0 + k < pulse_dat.size(); k++) begin
      chk("burst_order", pulse_dat[k0 + k], 8'h41 + 8'(k));
      if (k > 0) chk("burst_spacing", pulse_cyc[k0 + k] - pulse_cyc[k0 + k - 1], BUSY_GUARD + 1);
    end
    core_sleep = 1'b1;
    tick();

    // Core stays gated well past the wake timeout, then wakes.
    evt_valid = 1'b1; evt_data = 8'h50;
    tick();
    evt_valid = 1'b0;
    repeat (100) tick();
    chk("timeout_err", wake_err, 1);
    chk("timeout_wake", wake, 1);
    core_sleep = 1'b0;
    p0 = pulse_cnt;
    for (int i = 0; i < 10 && pulse !== 1'b1; i++) tick();
    chk("timeout_pulse", pulse_cnt - p0, 1);

    // Long busy after a pulse holds back the next one until busy falls.
    core_busy = 1'b1;
    evt_valid = 1'b1; evt_data = 8'h60;
    tick();
    evt_valid = 1'b0;
    p0 = pulse_cnt;
    repeat (79) tick();
    chk("busy_hold", pulse_cnt - p0, 0);
    core_busy = 1'b0;
    for (int i = 0; i < 5 && pulse !== 1'b1; i++) tick();
    chk("busy_release", pulse_cnt - p0, 1);
    chk("busy_data", instr_data, 8'h60);

    // Busy blip during the idle countdown restarts it.
    repeat (50) tick();
    core_busy = 1'b1;
    tick();
    core_busy = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && wake === 1'b1; i++) begin tick(); n++; end
    chk("idle_restart", (n >= IDLE_CYCLES) ? 1 : 0, 1);
    chk("idle_sleep", wake, 0);

    // Reset while spacing pulses with two events still queued.
    core_sleep = 1'b0;
    for (int k = 0; k < 3; k++) begin
      evt_valid = 1'b1; evt_data = 8'h70 + 8'(k);
      tick();
    end
    evt_valid = 1'b0;
    p0 = pulse_cnt;
    for (int i = 0; i < 10 && pulse !== 1'b1; i++) tick();
    chk("pre_reset_pulse", pulse_cnt - p0, 1);
    repeat (5) tick();
    chk("pre_reset_level", fifo_level, 2);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("post_reset_level", fifo_level, 0);
    chk("post_reset_wake", wake, 0);
    chk("post_reset_err", wake_err, 0);
    p0 = pulse_cnt;
    repeat (100) tick();
    chk("post_reset_pulses", pulse_cnt - p0, 0);

    // Randomized traffic, re-gating, busy and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      evt_valid = ($urandom_range(0, 4) == 0);
      evt_data  = 8'($urandom_range(0, 255));
      core_busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) core_sleep = ~core_sleep;
      resetn = ($urandom_range(0, 699) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
